// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer controller for an asynchronous FIFO.
// Keeps the binary write pointer and publishes its Gray form to the read domain.
// Derives full, almost-full and occupancy from the synchronised Gray read pointer.
// Optional sticky overflow flag: define FIFO_WPTR_OVF_EN to add the ovf_o port.
module fifo_wptr_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 3,
  parameter int unsigned ALMOST_FULL_THR = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync_i,
  output logic                  wen_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [ADDR_WIDTH:0]   wptr_gray_o,
  output logic                  full_o,
  output logic                  almost_full_o,
`ifdef FIFO_WPTR_OVF_EN
  output logic                  ovf_o,
`endif
  output logic [ADDR_WIDTH:0]   level_o
);

  localparam logic [ADDR_WIDTH:0] AfThr = (ADDR_WIDTH + 1)'(ALMOST_FULL_THR);

  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] wgray_q, wgray_d;
  logic [ADDR_WIDTH:0] level_q, level_d;
  logic                full_q, full_d;
  logic                af_q, af_d;
  logic [ADDR_WIDTH:0] rbin;
  logic [ADDR_WIDTH:0] rgray_full;
  logic                accept;

  assign accept  = push_i & ~full_q;
  assign wen_o   = accept;
  assign waddr_o = wbin_q[ADDR_WIDTH-1:0];

  // Gray-to-binary conversion of the read pointer (prefix XOR from the MSB).
  always_comb begin
    rbin             = '0;
    rbin[ADDR_WIDTH] = rptr_gray_sync_i[ADDR_WIDTH];
    for (int i = int'(ADDR_WIDTH) - 1; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rptr_gray_sync_i[i];
    end
  end

  // Read pointer as it would look when the writer is exactly one lap ahead.
  assign rgray_full = {~rptr_gray_sync_i[ADDR_WIDTH:ADDR_WIDTH-1],
                       rptr_gray_sync_i[ADDR_WIDTH-2:0]};

  // Next pointer, occupancy and flags; almost-full follows the registered level.
  always_comb begin
    wbin_d  = wbin_q;
    if (accept) begin
      wbin_d = wbin_q + 1'b1;
    end
    wgray_d = wbin_d ^ (wbin_d >> 1);
    level_d = wbin_d - rbin;
    full_d  = (wgray_d == rgray_full);
    af_d    = (level_q >= AfThr);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
    end
  end

  assign wptr_gray_o   = wgray_q;
  assign level_o       = level_q;
  assign full_o        = full_q;
  assign almost_full_o = af_q;

`ifdef FIFO_WPTR_OVF_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q | (push_i & full_q);

  // Sticky overflow; only reset clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Bench for fifo_wptr_ctrl (ADDR_WIDTH=3, ALMOST_FULL_THR=6).
// Reference model counts accepted writes and reads as plain integers modulo 16.
module tb_fifo_wptr_ctrl;

  localparam int AW    = 3;
  localparam int THR   = 6;
  localparam int DEPTH = 8;
  localparam int MOD   = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          push_i;
  logic [AW:0]   rptr_gray_sync_i;
  logic          wen_o;
  logic [AW-1:0] waddr_o;
  logic [AW:0]   wptr_gray_o;
  logic          full_o;
  logic          almost_full_o;
  logic [AW:0]   level_o;
`ifdef FIFO_WPTR_OVF_EN
  logic          ovf_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int   w_m, r_m, lvl_m;
  logic full_m, af_m, ovf_m;

  fifo_wptr_ctrl #(
    .ADDR_WIDTH      (AW),
    .ALMOST_FULL_THR (THR)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .push_i           (push_i),
    .rptr_gray_sync_i (rptr_gray_sync_i),
    .wen_o            (wen_o),
    .waddr_o          (waddr_o),
    .wptr_gray_o      (wptr_gray_o),
    .full_o           (full_o),
    .almost_full_o    (almost_full_o),
`ifdef FIFO_WPTR_OVF_EN
    .ovf_o            (ovf_o),
`endif
    .level_o          (level_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [3:0] gray4(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    w_m = 0; r_m = 0; lvl_m = 0;
    full_m = 1'b0; af_m = 1'b0; ovf_m = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".gray"},  32'(wptr_gray_o),   32'(gray4(w_m)));
    check({tag, ".level"}, 32'(level_o),       32'(lvl_m));
    check({tag, ".full"},  32'(full_o),        32'(full_m));
    check({tag, ".af"},    32'(almost_full_o), 32'(af_m));
`ifdef FIFO_WPTR_OVF_EN
    check({tag, ".ovf"},   32'(ovf_o),         32'(ovf_m));
`endif
  endtask

  // One cycle: drive inputs, check write strobe/address, clock, check registered outputs.
  task automatic step(input logic push, input int rb, input string tag);
    logic acc;
    push_i           = push;
    r_m              = rb % MOD;
    rptr_gray_sync_i = gray4(r_m);
    acc              = push && !full_m;
    #1;
    check({tag, ".wen"},   32'(wen_o),   32'(acc));
    check({tag, ".waddr"}, 32'(waddr_o), 32'(w_m % DEPTH));
    @(posedge clk_i);
    ovf_m  = ovf_m | (push && full_m);
    af_m   = (lvl_m >= THR);
    if (acc) w_m = (w_m + 1) % MOD;
    lvl_m  = (w_m - r_m + MOD) % MOD;
    full_m = (lvl_m == DEPTH);
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset();
    rst_ni           = 1'b0;
    push_i           = 1'b0;
    rptr_gray_sync_i = '0;
    model_reset();
    #1;
    check_regs("reset");
    check("reset.wen", 32'(wen_o), 32'(push_i));
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int seq [8] = '{1, 3, 2, 6, 7, 5, 4, 12};
    int rb;

    do_reset();

    // Eight pushes from empty: Gray sequence, full and level 8 at the end.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 0, "fill");
      check("fill.seq", 32'(wptr_gray_o), 32'(seq[i]));
    end
    check("fill.full8", 32'(full_o), 32'd1);
    check("fill.lvl8",  32'(level_o), 32'd8);

    // Pushes while full are dropped.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, "ovf");
      check("ovf.hold", 32'(wptr_gray_o), 32'd12);
    end
`ifdef FIFO_WPTR_OVF_EN
    check("ovf.sticky", 32'(ovf_o), 32'd1);
`endif

    // Read pointer jumps to 3: level 5, almost-full drops a cycle later.
    step(1'b0, 3, "drain");
    check("drain.full", 32'(full_o), 32'd0);
    check("drain.lvl5", 32'(level_o), 32'd5);
    check("drain.af1",  32'(almost_full_o), 32'd1);
    step(1'b0, 3, "drain2");
    check("drain2.af0", 32'(almost_full_o), 32'd0);
`ifdef FIFO_WPTR_OVF_EN
    check("drain2.ovf", 32'(ovf_o), 32'd1);
`endif

    // Six accepts from empty: level 6, then almost-full.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 0, "af");
    check("af.lvl6", 32'(level_o), 32'd6);
    check("af.af0",  32'(almost_full_o), 32'd0);
    step(1'b0, 0, "af2");
    check("af2.af1", 32'(almost_full_o), 32'd1);

    // Wrap: sixteen accepts, read pointer lagging two cycles.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rb = (i >= 2) ? i - 2 : 0;
      step(1'b1, rb, "wrap");
      check("wrap.nofull", 32'(full_o), 32'd0);
    end
    check("wrap.gray0", 32'(wptr_gray_o), 32'd0);

    // Random traffic: write-heavy, then read-heavy.
    do_reset();
    rb = 0;
    for (int i = 0; i < 400; i++) begin
      int rd_odds;
      rd_odds = (i < 200) ? 3 : 1;
      if (((w_m - rb + MOD) % MOD) > 0 && $urandom_range(0, rd_odds) == 0) rb = (rb + 1) % MOD;
      step(logic'($urandom_range(0, 3) != 0), rb, "rand");
    end

    // Mid-operation asynchronous reset.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 0, "pre");
    #2;
    rst_ni = 1'b0;
    push_i = 1'b0;
    rptr_gray_sync_i = '0;
    model_reset();
    #1;
    check_regs("arst");
    check("arst.waddr", 32'(waddr_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b1, 0, "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
